axi_replay_initiator: RTL and testbench
=======================================

// Module: axi_replay_initiator
// PURPOSE
//  Synthesizable AXI4 initiator that turns a stream of compact commands into complete single-ID
//  AXI write (AW/W/B) or read (AR/R) transactions. It drives traffic onto a bus that axi_dumper
//  can log, serving as a deterministic traffic source for tracing benches and bring-up.
//  One transaction is in flight at a time. It keeps running write/read/error counts and a read XOR checksum.
// PARAMETERS
//  AddrWidth   32     address width of cmd_addr_i and AW/AR addr
//  DataWidth   64     AXI data width; data beats are DataWidth/8 bytes
//  IdWidth     4      AXI ID width of cmd_id_i
//  CntWidth    32     width of the statistics counters
//  axi_req_t   logic  AXI request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready)
//  axi_resp_t  logic  AXI response struct (aw_ready, ar_ready, w_ready, b, b_valid, r, r_valid)
// PORTS
//  clk_i          in   1          clock, all logic on rising edge
//  rst_i          in   1          synchronous reset, active-high
//  cmd_valid_i    in   1          command valid
//  cmd_ready_o    out  1          command accepted when valid&&ready
//  cmd_write_i    in   1          1 = write transaction, 0 = read transaction
//  cmd_addr_i     in   AddrWidth  start address
//  cmd_len_i      in   8          AXI len; the burst has len+1 beats
//  cmd_id_i       in   IdWidth    AXI ID
//  cmd_data_i     in   DataWidth  write data seed; beat k carries seed+k (mod 2^DataWidth)
//  axi_req_o      out  axi_req_t  AXI request channels
//  axi_resp_i     in   axi_resp_t AXI response channels
//  busy_o         out  1          high in every state except IDLE
//  wr_cnt_o       out  CntWidth   completed writes (B handshakes)
//  rd_cnt_o       out  CntWidth   completed reads (R last handshakes)
//  err_cnt_o      out  CntWidth   erroneous transactions, saturates at all-ones
//  rd_xor_o       out  DataWidth  XOR of all accepted R data beats
// BEHAVIOUR
//  Reset (rst_i high at an edge): state IDLE; all req valids/readies 0; all counters and
//   rd_xor_o 0; beat counter 0. cmd_ready_o = (state==IDLE) && !rst_i.
//  Fixed AXI fields: size=$clog2(DataWidth/8), burst=INCR, strb all ones; all other fields 0.
//  FSM states: IDLE, AW, W, B, AR, R.
//   IDLE: on cmd handshake, latch all cmd fields and go to AW (write) or AR (read).
//         The command is accepted at cycle 0; the valid is asserted at cycle 1.
//   AW: aw_valid=1 with stable fields until aw_ready. On the handshake go to W, beat counter cleared.
//   W: w_valid=1; data=seed+beat; last=(beat==len). On each w handshake beat++. The handshake on the
//      last beat goes to B. W is never asserted before the AW handshake completes.
//   B: b_ready=1. On b_valid: wr_cnt++; err if b.resp!=0 or b.id!=latched id. Go to IDLE.
//   AR: ar_valid=1 until ar_ready, then go to R with the beat counter cleared.
//   R: r_ready=1. On each r handshake: rd_xor ^= r.data; beat++.
//      The transaction is erroneous if any beat has resp!=0 or id mismatch, or if r.last
//      arrives at beat!=len, or if beat>len without last.
//      On r.last: rd_cnt++, err_cnt++ once if the transaction was erroneous, then go to IDLE.
//  Error counting: at most one err_cnt increment per transaction, taken at completion.
//  Valid stability: once asserted, a valid and its payload stay constant until the handshake.
//  Minimum latency, all readies high: write cmd at c0 -> AW c1 -> W beats c2..c2+len ->
//   B accepted c3+len -> cmd_ready_o high c4+len. Read: AR c1, R from c2, IDLE after last.
//  Counter wrap: wr_cnt and rd_cnt wrap modulo 2^CntWidth; err_cnt saturates.
//   Beat counter is 9 bits, so len=255 does not wrap.
//  Reset mid-transaction: abandon the transaction at the next edge (valids drop, counters clear).
//   The bench is responsible for resetting the subordinate too.
//  Responses arriving in the wrong state (b_valid outside B, r_valid outside R) are ignored,
//   and ready stays 0 for them.
// TESTING
//  1 write addr=0x1000 len=3 id=2 seed=0x10, all readies high -> W data 0x10..0x13, last on 4th beat,
//    wr_cnt=1, err_cnt=0, cmd_ready_o back at cycle 7
//  2 read len=1; subordinate returns 0xF0, 0x0F with last on beat 2 -> rd_xor=0xFF, rd_cnt=1
//  3 aw_ready held low 5 cycles with random W/B stalls -> aw fields stable, no W beat before the AW
//    handshake, counters identical to scenario 1
//  4 read len=3; subordinate asserts r.last on beat 2 and returns SLVERR on beat 1 -> err_cnt=1 (not 2),
//    rd_cnt=1, state returns to IDLE
//  5 write with B id=5 vs cmd id=2 -> err_cnt=1; then 2^CntWidth-1 errors preloaded -> err_cnt holds all-ones
//  6 rst_i pulse during the W beat 2 of len=7 -> next cycle all valids 0, counters 0,
//    cmd_ready_o=1 after rst_i drops

Source files
------------

// File: rtl/axi_replay_initiator.sv
// Command-driven AXI4 traffic source: each accepted command becomes one complete write (AW/W/B)
// or read (AR/R) burst, with running write/read/error counts and an XOR checksum of read data.

package axi_replay_pkg;
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
   } ax_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      r_chan_t r;
      logic    r_valid;
   } axi_resp_t;
endpackage

module axi_replay_initiator #(
   parameter int  AddrWidth  = 32,
   parameter int  DataWidth  = 64,
   parameter int  IdWidth    = 4,
   parameter int  CntWidth   = 32,
   parameter type axi_req_t  = axi_replay_pkg::axi_req_t,
   parameter type axi_resp_t = axi_replay_pkg::axi_resp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_write_i,
   input  logic [AddrWidth-1:0] cmd_addr_i,
   input  logic [7:0]           cmd_len_i,
   input  logic [IdWidth-1:0]   cmd_id_i,
   input  logic [DataWidth-1:0] cmd_data_i,
   output axi_req_t             axi_req_o,
   input  axi_resp_t            axi_resp_i,
   output logic                 busy_o,
   output logic [CntWidth-1:0]  wr_cnt_o,
   output logic [CntWidth-1:0]  rd_cnt_o,
   output logic [CntWidth-1:0]  err_cnt_o,
   output logic [DataWidth-1:0] rd_xor_o
);
   localparam logic [2:0] SizeVal = 3'($clog2(DataWidth / 8));

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

   state_t               state_r;
   logic [AddrWidth-1:0] addr_r;
   logic [7:0]           len_r;
   logic [IdWidth-1:0]   id_r;
   logic [DataWidth-1:0] seed_r;
   logic [8:0]           beat_r;
   logic                 txn_err_r;
   logic [CntWidth-1:0]  wr_cnt_r;
   logic [CntWidth-1:0]  rd_cnt_r;
   logic [CntWidth-1:0]  err_cnt_r;
   logic [DataWidth-1:0] rd_xor_r;
   logic                 b_err_s;
   logic                 r_beat_err_s;
   logic                 at_last_s;

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] val);
      if (val == {CntWidth{1'b1}}) begin
         return val;
      end else begin
         return val + CntWidth'(1);
      end
   endfunction

   // Per-response error classification against the latched command.
   always_comb begin
      at_last_s    = (beat_r == {1'b0, len_r});
      b_err_s      = (axi_resp_i.b.resp != 2'b00) || (axi_resp_i.b.id != id_r);
      r_beat_err_s = (axi_resp_i.r.resp != 2'b00) || (axi_resp_i.r.id != id_r) ||
                     (axi_resp_i.r.last && !at_last_s) ||
                     (!axi_resp_i.r.last && (beat_r > {1'b0, len_r}));
   end

   // Transaction sequencer and statistics.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= S_IDLE;
         addr_r    <= '0;
         len_r     <= 8'd0;
         id_r      <= '0;
         seed_r    <= '0;
         beat_r    <= 9'd0;
         txn_err_r <= 1'b0;
         wr_cnt_r  <= '0;
         rd_cnt_r  <= '0;
         err_cnt_r <= '0;
         rd_xor_r  <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  addr_r    <= cmd_addr_i;
                  len_r     <= cmd_len_i;
                  id_r      <= cmd_id_i;
                  seed_r    <= cmd_data_i;
                  beat_r    <= 9'd0;
                  txn_err_r <= 1'b0;
                  state_r   <= cmd_write_i ? S_AW : S_AR;
               end
            end
            S_AW: begin
               if (axi_resp_i.aw_ready) begin
                  beat_r  <= 9'd0;
                  state_r <= S_W;
               end
            end
            S_W: begin
               if (axi_resp_i.w_ready) begin
                  beat_r <= beat_r + 9'd1;
                  if (at_last_s) begin
                     state_r <= S_B;
                  end
               end
            end
            S_B: begin
               if (axi_resp_i.b_valid) begin
                  wr_cnt_r <= wr_cnt_r + CntWidth'(1);
                  if (b_err_s) begin
                     err_cnt_r <= sat_inc(err_cnt_r);
                  end
                  state_r <= S_IDLE;
               end
            end
            S_AR: begin
               if (axi_resp_i.ar_ready) begin
                  beat_r  <= 9'd0;
                  state_r <= S_R;
               end
            end
            S_R: begin
               if (axi_resp_i.r_valid) begin
                  rd_xor_r <= rd_xor_r ^ axi_resp_i.r.data;
                  beat_r   <= beat_r + 9'd1;
                  // Errors accumulate per beat but are counted once, when the burst closes.
                  if (axi_resp_i.r.last) begin
                     rd_cnt_r  <= rd_cnt_r + CntWidth'(1);
                     txn_err_r <= 1'b0;
                     if (txn_err_r || r_beat_err_s) begin
                        err_cnt_r <= sat_inc(err_cnt_r);
                     end
                     state_r <= S_IDLE;
                  end else begin
                     txn_err_r <= txn_err_r | r_beat_err_s;
                  end
               end
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

   // Channel payloads are pure decodes of registered state, so they hold steady until handshake.
   always_comb begin
      axi_req_o           = '0;
      axi_req_o.aw.id     = id_r;
      axi_req_o.aw.addr   = addr_r;
      axi_req_o.aw.len    = len_r;
      axi_req_o.aw.size   = SizeVal;
      axi_req_o.aw.burst  = 2'b01;
      axi_req_o.aw_valid  = (state_r == S_AW);
      axi_req_o.w.data    = seed_r + DataWidth'(beat_r);
      axi_req_o.w.strb    = '1;
      axi_req_o.w.last    = at_last_s;
      axi_req_o.w_valid   = (state_r == S_W);
      axi_req_o.b_ready   = (state_r == S_B);
      axi_req_o.ar.id     = id_r;
      axi_req_o.ar.addr   = addr_r;
      axi_req_o.ar.len    = len_r;
      axi_req_o.ar.size   = SizeVal;
      axi_req_o.ar.burst  = 2'b01;
      axi_req_o.ar_valid  = (state_r == S_AR);
      axi_req_o.r_ready   = (state_r == S_R);
   end

   assign cmd_ready_o = (state_r == S_IDLE) && !rst_i;
   assign busy_o      = (state_r != S_IDLE);
   assign wr_cnt_o    = wr_cnt_r;
   assign rd_cnt_o    = rd_cnt_r;
   assign err_cnt_o   = err_cnt_r;
   assign rd_xor_o    = rd_xor_r;
endmodule

// File: tb/tb_axi_replay_initiator.sv
// Bench for axi_replay_initiator: a cycle-driven subordinate plus a transaction-level
// reference model of the counters, checksum and write data stream.
module tb_axi_replay_initiator;
   import axi_replay_pkg::*;
   localparam int CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, cmd_valid, cmd_ready, cmd_write, busy;
   logic [31:0]    cmd_addr;
   logic [7:0]     cmd_len;
   logic [3:0]     cmd_id;
   logic [63:0]    cmd_data, rd_xor;
   logic [CW-1:0]  wr_cnt, rd_cnt, err_cnt;
   axi_req_t       req;
   axi_resp_t      resp;

   axi_replay_initiator #(
      .AddrWidth(32), .DataWidth(64), .IdWidth(4), .CntWidth(CW),
      .axi_req_t(axi_req_t), .axi_resp_t(axi_resp_t)
   ) dut (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_id_i(cmd_id),
      .cmd_data_i(cmd_data), .axi_req_o(req), .axi_resp_i(resp), .busy_o(busy),
      .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt), .err_cnt_o(err_cnt), .rd_xor_o(rd_xor)
   );

   int checks = 0;
   int failures = 0;

   logic [CW-1:0] m_wr, m_rd, m_err;
   logic [63:0]   m_xor;

   int          stall_pct = 0;
   int          aw_hold = 0;
   int          rst_at_beat = -1;
   logic [1:0]  b_resp_k = 2'b00;
   logic [3:0]  b_id_k = 4'd0;
   logic [63:0] rq_data[$];
   logic [1:0]  rq_resp[$];
   logic [3:0]  rq_id[$];
   logic        rq_last[$];

   logic [63:0] w_data_q[$];
   logic        w_last_q[$];
   int          ax_unstable, w_early, w_unstable, done_cyc;
   bit          timed_out, aborted, cmd_rdy_c0;
   ax_chan_t    ax_seen;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; cmd_valid = 1'b0; resp = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_wr = '0; m_rd = '0; m_err = '0; m_xor = 64'd0;
   endtask

   function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction

   task automatic model_write(input logic [3:0] id);
      m_wr = m_wr + 1'b1;
      if (b_resp_k != 2'b00 || b_id_k != id) m_err = sat(m_err);
   endtask

   task automatic model_read(input logic [7:0] len, input logic [3:0] id);
      bit e = 1'b0;
      for (int k = 0; k < rq_data.size(); k++) begin
         m_xor ^= rq_data[k];
         if (rq_resp[k] != 2'b00 || rq_id[k] != id) e = 1'b1;
         if (rq_last[k]) begin
            if (k != int'(len)) e = 1'b1;
            break;
         end
      end
      m_rd = m_rd + 1'b1;
      if (e) m_err = sat(m_err);
   endtask

   task automatic build_read(input int lastpos, input logic [3:0] id, input int errbeat, input int badid);
      rq_data.delete(); rq_resp.delete(); rq_id.delete(); rq_last.delete();
      for (int k = 0; k <= lastpos; k++) begin
         rq_data.push_back({$urandom, $urandom});
         rq_resp.push_back(k == errbeat ? 2'b10 : 2'b00);
         rq_id.push_back(k == badid ? id ^ 4'd1 : id);
         rq_last.push_back(k == lastpos);
      end
   endtask

   // Runs one command end to end, acting as subordinate; leaves the bench at the negedge after completion.
   task automatic drive_txn(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] id, input logic [63:0] seed);
      int cyc, aw_low, r_idx, wcount;
      bit done, ax_done, have_ax, have_w, cmd_hs, ax_hs, w_hs, b_hs, r_hs, r_last, ax_v, w_l;
      logic [63:0] w_d;
      w_chan_t w_hold;
      ax_chan_t ax_cur;
      w_data_q.delete(); w_last_q.delete();
      ax_unstable = 0; w_early = 0; w_unstable = 0; done_cyc = -1;
      timed_out = 1'b0; aborted = 1'b0;
      aw_low = aw_hold; r_idx = 0; wcount = 0; cyc = 0;
      done = 1'b0; ax_done = 1'b0; have_ax = 1'b0; have_w = 1'b0; w_hold = '0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id; cmd_data = seed;
      while (!done && cyc < 3000) begin
         ax_v   = wr ? req.aw_valid : req.ar_valid;
         ax_cur = wr ? req.aw : req.ar;
         if (cyc == 0) cmd_rdy_c0 = cmd_ready;
         if (ax_v) begin
            if (!have_ax) begin ax_seen = ax_cur; have_ax = 1'b1; end
            else if (ax_cur !== ax_seen) ax_unstable++;
         end
         if (req.w_valid && !ax_done) w_early++;
         if (req.w_valid && have_w && req.w !== w_hold) w_unstable++;
         resp = '0;
         resp.aw_ready = wr && (aw_low == 0);
         resp.ar_ready = !wr && (aw_low == 0);
         resp.w_ready  = ($urandom_range(99) >= stall_pct);
         resp.b_valid  = wr && (wcount == int'(len) + 1) && ($urandom_range(99) >= stall_pct);
         resp.b.resp   = b_resp_k;
         resp.b.id     = b_id_k;
         if (!wr && ax_done && r_idx < rq_data.size() && $urandom_range(99) >= stall_pct) begin
            resp.r_valid = 1'b1;
            resp.r.data  = rq_data[r_idx];
            resp.r.resp  = rq_resp[r_idx];
            resp.r.id    = rq_id[r_idx];
            resp.r.last  = rq_last[r_idx];
         end
         if (rst_at_beat >= 0 && req.w_valid && wcount == rst_at_beat) rst = 1'b1;
         cmd_hs = cmd_valid && cmd_ready;
         ax_hs  = ax_v && (wr ? resp.aw_ready : resp.ar_ready);
         w_hs   = req.w_valid && resp.w_ready;
         b_hs   = req.b_ready && resp.b_valid;
         r_hs   = req.r_ready && resp.r_valid;
         r_last = resp.r.last;
         w_d    = req.w.data;
         w_l    = req.w.last;
         if (req.w_valid && !w_hs) begin have_w = 1'b1; w_hold = req.w; end
         else have_w = 1'b0;
         @(posedge clk);
         if (rst) begin
            aborted = 1'b1; done = 1'b1;
         end else begin
            if (ax_v && !ax_hs && aw_low > 0) aw_low--;
            if (ax_hs) ax_done = 1'b1;
            if (w_hs) begin w_data_q.push_back(w_d); w_last_q.push_back(w_l); wcount++; end
            if (r_hs) r_idx++;
            if (b_hs || (r_hs && r_last)) begin done = 1'b1; done_cyc = cyc; end
         end
         cyc++;
         @(negedge clk);
         if (cmd_hs) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      resp = '0;
      if (!done) timed_out = 1'b1;
   endtask

   function automatic int bad_wbeats(input logic [7:0] len, input logic [63:0] seed);
      int bad = 0;
      if (w_data_q.size() != int'(len) + 1) bad++;
      for (int k = 0; k < w_data_q.size(); k++) begin
         if (w_data_q[k] !== seed + 64'(k)) bad++;
         if (w_last_q[k] !== (k == int'(len))) bad++;
      end
      return bad;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; cmd_valid = 1'b0; resp = '0;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready_in_rst: got %b want 0", cmd_ready); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_wr = '0; m_rd = '0; m_err = '0; m_xor = 64'd0;
      #1;
      checks++;
      if ({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready, busy} !== 6'b0 ||
          {wr_cnt, rd_cnt, err_cnt} !== {3*CW{1'b0}} || rd_xor !== 64'd0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: valids=%b busy=%b wr=%0d rd=%0d err=%0d xor=%h rdy=%b want all 0, rdy=1",
                  {req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}, busy, wr_cnt, rd_cnt,
                  err_cnt, rd_xor, cmd_ready);
      end
   endtask

   task automatic test_idle_ignore();
      int bad = 0;
      @(negedge clk);
      resp = '0; resp.b_valid = 1'b1; resp.r_valid = 1'b1; resp.r.last = 1'b1; resp.r.data = 64'hDEAD;
      repeat (3) begin
         @(negedge clk);
         if (req.b_ready !== 1'b0 || req.r_ready !== 1'b0 || busy !== 1'b0) bad++;
      end
      resp = '0;
      checks++;
      if (bad != 0 || wr_cnt !== m_wr || rd_cnt !== m_rd || rd_xor !== m_xor) begin
         failures++;
         $display("FAIL idle_ignore: bad_cycles=%0d wr=%0d rd=%0d xor=%h want 0/%0d/%0d/%h", bad, wr_cnt, rd_cnt, rd_xor, m_wr, m_rd, m_xor);
      end
   endtask

   task automatic test_single_write();
      stall_pct = 0; aw_hold = 0; b_resp_k = 2'b00; b_id_k = 4'd2;
      drive_txn(1'b1, 32'h1000, 8'd3, 4'd2, 64'h10);
      model_write(4'd2);
      checks++;
      if (timed_out || bad_wbeats(8'd3, 64'h10) != 0) begin
         failures++; $display("FAIL t1_wdata: timeout=%b bad_beats=%0d want 0/0", timed_out, bad_wbeats(8'd3, 64'h10));
      end
      checks++;
      if (ax_seen.addr !== 32'h1000 || ax_seen.len !== 8'd3 || ax_seen.id !== 4'd2 || ax_seen.size !== 3'd3 ||
          ax_seen.burst !== 2'b01 || ax_seen.cache !== 4'd0) begin
         failures++; $display("FAIL t1_aw_fields: got %h want addr=1000 len=3 id=2 size=3 burst=1", ax_seen);
      end
      checks++;
      if (!cmd_rdy_c0 || done_cyc != 6 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL t1_latency: c0_rdy=%b b_cycle=%0d rdy_c7=%b busy=%b want 1/6/1/0", cmd_rdy_c0, done_cyc, cmd_ready, busy);
      end
      checks++;
      if (wr_cnt !== m_wr || err_cnt !== m_err || wr_cnt !== 4'd1) begin
         failures++; $display("FAIL t1_counters: wr=%0d err=%0d want %0d/%0d", wr_cnt, err_cnt, m_wr, m_err);
      end
   endtask

   task automatic test_read_xor();
      do_reset();
      stall_pct = 0; aw_hold = 0;
      build_read(1, 4'd3, -1, -1);
      rq_data[0] = 64'hF0; rq_data[1] = 64'h0F;
      drive_txn(1'b0, 32'h2000, 8'd1, 4'd3, 64'd0);
      model_read(8'd1, 4'd3);
      checks++;
      if (timed_out || rd_xor !== m_xor || rd_xor !== 64'hFF || rd_cnt !== m_rd || err_cnt !== m_err || busy !== 1'b0) begin
         failures++; $display("FAIL t2_read_xor: timeout=%b xor=%h rd=%0d err=%0d busy=%b want 00ff/%0d/%0d/0", timed_out, rd_xor, rd_cnt, err_cnt, busy, m_rd, m_err);
      end
   endtask

   task automatic test_aw_stall();
      do_reset();
      stall_pct = 40; aw_hold = 5; b_resp_k = 2'b00; b_id_k = 4'd2;
      drive_txn(1'b1, 32'h1000, 8'd3, 4'd2, 64'h10);
      model_write(4'd2);
      checks++;
      if (timed_out || ax_unstable != 0 || w_early != 0 || w_unstable != 0) begin
         failures++; $display("FAIL t3_stability: timeout=%b aw_unstable=%0d w_early=%0d w_unstable=%0d want 0", timed_out, ax_unstable, w_early, w_unstable);
      end
      checks++;
      if (bad_wbeats(8'd3, 64'h10) != 0 || wr_cnt !== m_wr || err_cnt !== m_err || wr_cnt !== 4'd1) begin
         failures++; $display("FAIL t3_result: bad_beats=%0d wr=%0d err=%0d want 0/%0d/%0d", bad_wbeats(8'd3, 64'h10), wr_cnt, err_cnt, m_wr, m_err);
      end
      stall_pct = 0; aw_hold = 0;
   endtask

   task automatic test_read_error();
      logic [CW-1:0] err_before;
      err_before = err_cnt;
      build_read(2, 4'd6, 1, -1);
      drive_txn(1'b0, 32'h3000, 8'd3, 4'd6, 64'd0);
      model_read(8'd3, 4'd6);
      checks++;
      if (timed_out || err_cnt !== m_err || err_cnt !== err_before + 1'b1 || rd_cnt !== m_rd || rd_xor !== m_xor ||
          busy !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++; $display("FAIL t4_read_err: err=%0d rd=%0d xor=%h busy=%b want %0d/%0d/%h/0", err_cnt, rd_cnt, rd_xor, busy, m_err, m_rd, m_xor);
      end
   endtask

   task automatic test_err_saturate();
      do_reset();
      b_resp_k = 2'b00; b_id_k = 4'd5;
      drive_txn(1'b1, 32'h40, 8'd1, 4'd2, 64'h77);
      model_write(4'd2);
      checks++;
      if (err_cnt !== m_err || err_cnt !== 4'd1) begin
         failures++; $display("FAIL t5_bid_mismatch: err=%0d want 1", err_cnt);
      end
      b_resp_k = 2'b10; b_id_k = 4'd2;
      for (int i = 0; i < (1 << CW); i++) begin
         drive_txn(1'b1, 32'h80, 8'd0, 4'd2, 64'(i));
         model_write(4'd2);
      end
      checks++;
      if (err_cnt !== {CW{1'b1}} || err_cnt !== m_err || wr_cnt !== m_wr) begin
         failures++; $display("FAIL t5_saturate: err=%0d wr=%0d want %0d/%0d", err_cnt, wr_cnt, m_err, m_wr);
      end
      b_resp_k = 2'b00;
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int n = 0; n < 24; n++) begin
         logic        wr;
         logic [7:0]  len;
         logic [3:0]  id;
         logic [63:0] seed;
         int          lastpos;
         wr = 1'($urandom_range(1)); len = 8'($urandom_range(7)); id = 4'($urandom);
         seed = {$urandom, $urandom};
         stall_pct = $urandom_range(50); aw_hold = $urandom_range(3);
         b_resp_k = ($urandom_range(3) == 0) ? 2'b10 : 2'b00;
         b_id_k = ($urandom_range(4) == 0) ? id ^ 4'd8 : id;
         lastpos = int'(len);
         if ($urandom_range(4) == 0) lastpos = (len > 0 && $urandom_range(1) == 0) ? int'(len) - 1 : int'(len) + 1;
         build_read(lastpos, id, ($urandom_range(5) == 0) ? int'($urandom_range(lastpos)) : -1,
                    ($urandom_range(7) == 0) ? int'($urandom_range(lastpos)) : -1);
         drive_txn(wr, $urandom, len, id, seed);
         if (wr) model_write(id);
         else    model_read(len, id);
         if (timed_out || ax_unstable != 0 || w_early != 0 || w_unstable != 0 || busy !== 1'b0) bad++;
         if (wr && bad_wbeats(len, seed) != 0) bad++;
         if (ax_seen.len !== len || ax_seen.id !== id) bad++;
         checks++;
         if (wr_cnt !== m_wr || rd_cnt !== m_rd || err_cnt !== m_err || rd_xor !== m_xor) begin
            failures++;
            $display("FAIL rand_counters[%0d]: wr=%0d rd=%0d err=%0d xor=%h want %0d/%0d/%0d/%h", n, wr_cnt, rd_cnt, err_cnt, rd_xor, m_wr, m_rd, m_err, m_xor);
         end
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL rand_protocol: violations=%0d want 0", bad); end
      stall_pct = 0; aw_hold = 0; b_resp_k = 2'b00;
   endtask

   task automatic test_mid_reset();
      b_resp_k = 2'b00; b_id_k = 4'd2;
      drive_txn(1'b1, 32'h500, 8'd0, 4'd2, 64'd1);
      model_write(4'd2);
      rst_at_beat = 2;
      drive_txn(1'b1, 32'h600, 8'd7, 4'd2, 64'h100);
      rst_at_beat = -1;
      checks++;
      if (!aborted || {req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready} !== 5'b0 ||
          {wr_cnt, rd_cnt, err_cnt} !== {3*CW{1'b0}} || rd_xor !== 64'd0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL t6_abort: aborted=%b valids=%b wr=%0d busy=%b rdy=%b want 1/0/0/0/0", aborted,
                  {req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}, wr_cnt, busy, cmd_ready);
      end
      rst = 1'b0;
      m_wr = '0; m_rd = '0; m_err = '0; m_xor = 64'd0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL t6_ready_after: got %b want 1", cmd_ready); end
      drive_txn(1'b1, 32'h700, 8'd2, 4'd2, 64'h20);
      model_write(4'd2);
      checks++;
      if (timed_out || bad_wbeats(8'd2, 64'h20) != 0 || wr_cnt !== m_wr) begin
         failures++; $display("FAIL t6_recover: timeout=%b wr=%0d want 0/%0d", timed_out, wr_cnt, m_wr);
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
      cmd_id = 4'd0; cmd_data = 64'd0; resp = '0;
      m_wr = '0; m_rd = '0; m_err = '0; m_xor = 64'd0;
      test_reset();
      test_idle_ignore();
      test_single_write();
      test_read_xor();
      test_aw_stall();
      test_read_error();
      test_err_saturate();
      test_random();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
